// File: rtl/wb_result_fifo_pkg.sv
// Shared constants and types for the Wishbone result FIFO.
// Register offsets, STATUS/CTRL bit positions and FSM state type.
package wb_result_fifo_pkg;

  localparam logic [3:0] OFS_DATA   = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_CTRL   = 4'h8;
  localparam logic [3:0] OFS_THRESH = 4'hC;

  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_OVF   = 18;
  localparam int ST_UDF   = 19;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

endpackage

// File: rtl/wb_result_fifo_if.sv
// Wishbone classic bus bundle between initiator and result FIFO.
// Signal names keep the bus-side _i/_o suffixes of the responder.
interface wb_result_fifo_if;
  logic [31:0] addr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        cyc_i;
  logic        stb_i;
  logic        lock_i;
  logic        tagn_i;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport slave (
    input  addr_i, dat_i, we_i, sel_i,
    input  cyc_i, stb_i, lock_i, tagn_i,
    output dat_o, ack_o, err_o, rty_o
  );

  modport master (
    output addr_i, dat_i, we_i, sel_i,
    output cyc_i, stb_i, lock_i, tagn_i,
    input  dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wb_result_fifo_mem.sv
// FIFO storage: synchronous write, combinational read, no reset.
module wb_result_fifo_mem #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_result_fifo.sv
// Wishbone responder buffering 32-bit result words in a FIFO.
// Optional WB_RESULT_FIFO_IRQ_EN adds a threshold interrupt irq_o.
module wb_result_fifo
  import wb_result_fifo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0300,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef WB_RESULT_FIFO_IRQ_EN
  output logic irq_o,
`endif
  wb_result_fifo_if.slave bus
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(2**DEPTH_LOG2);
  localparam logic [CW-1:0] THR_RST  = CW'(2**(DEPTH_LOG2-1));

  state_t state_q, state_d;

  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [CW-1:0] count, thresh;
  logic ovf, udf, ack_q, err_q, rty_q;
  logic ack_d, err_d, rty_d;
  logic [31:0] dat_q, rdat_d, status, mem_rdata;
  logic push, pop, flush, clr, set_ovf, set_udf, thr_we;
  logic hit, empty, full;
  logic [3:0] ofs;
  logic unused;

  assign unused = ^{bus.lock_i, bus.tagn_i};

  assign ofs   = bus.addr_i[3:0];
  assign hit   = bus.cyc_i & bus.stb_i &
                 (bus.addr_i[31:4] == BASE_ADDR[31:4]);
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  always_comb begin
    status = '0;
    status[DEPTH_LOG2:0] = count;
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_OVF]   = ovf;
    status[ST_UDF]   = udf;
  end

  wb_result_fifo_mem #(.AW(DEPTH_LOG2), .DW(32)) u_mem (
    .clk   (clk_i),
    .we    (push),
    .waddr (wp),
    .wdata (bus.dat_i),
    .raddr (rp),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    rdat_d  = '0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    clr     = 1'b0;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    thr_we  = 1'b0;
    unique case (state_q)
      S_IDLE: if (hit) begin
        state_d = S_RESP;
        if (bus.addr_i[1:0] != 2'b00) begin
          err_d = 1'b1;
        end else begin
          case (ofs)
            OFS_DATA: begin
              if (bus.we_i) begin
                if (bus.sel_i != 4'hF) err_d = 1'b1;
                else if (full) begin
                  rty_d   = 1'b1;
                  set_ovf = 1'b1;
                end else begin
                  ack_d = 1'b1;
                  push  = 1'b1;
                end
              end else if (empty) begin
                rty_d   = 1'b1;
                set_udf = 1'b1;
              end else begin
                ack_d  = 1'b1;
                pop    = 1'b1;
                rdat_d = mem_rdata;
              end
            end
            OFS_STATUS: begin
              if (bus.we_i) err_d = 1'b1;
              else begin
                ack_d  = 1'b1;
                rdat_d = status;
              end
            end
            OFS_CTRL: begin
              ack_d = 1'b1;
              if (bus.we_i) begin
                flush = bus.dat_i[CTRL_FLUSH];
                clr   = bus.dat_i[CTRL_CLR];
              end
            end
            OFS_THRESH: begin
              ack_d = 1'b1;
              if (bus.we_i) thr_we = bus.sel_i[0];
              else rdat_d = 32'(thresh);
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      dat_q   <= '0;
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      thresh  <= THR_RST;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      dat_q   <= rdat_d;
      if (flush) begin
        wp    <= '0;
        rp    <= '0;
        count <= '0;
      end else if (push) begin
        wp    <= wp + 1'b1;
        count <= count + 1'b1;
      end else if (pop) begin
        rp    <= rp + 1'b1;
        count <= count - 1'b1;
      end
      if (clr) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (set_ovf) ovf <= 1'b1;
        if (set_udf) udf <= 1'b1;
      end
      if (thr_we) thresh <= bus.dat_i[CW-1:0];
    end
  end

`ifdef WB_RESULT_FIFO_IRQ_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_o <= 1'b0;
    else irq_o <= (thresh != '0) && (count >= thresh);
  end
`endif

  assign bus.ack_o = ack_q;
  assign bus.err_o = err_q;
  assign bus.rty_o = rty_q;
  assign bus.dat_o = dat_q;

endmodule
